seg7_scan: RTL and testbench

- Downstream consumer of the 1 kHz scan clock produced by `clk_gen`. It time-multiplexes a NUM_DIGITS-digit common-anode 7-segment display: one digit per scan tick.
- Runs entirely on the system clock `clk`. `clk_1K` is sampled as a data signal and edge-detected; it is never used as a clock.
- Shows hex digits from the CPU debug value. Supports per-digit enable, decimal points, leading-zero blanking, tear-free frame latching and anti-ghosting blank time.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_scan_if.sv | 28 ++
 rtl/hex_to_seg7.sv | 15 +
 rtl/seg7_scan.sv | 159 +++++++++++++++
 tb/tb_seg7_scan.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg : scan states, hex font and segment constants for seg7_scan |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-high {g,f,e,d,c,b,a}, indexed by the hex nibble.
   localparam logic [6:0] FONT [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_if : display-side signal bundle of the 7-segment scanner   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
interface seg7_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      clk_1K;
   logic [4*NUM_DIGITS-1:0]   value;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic [NUM_DIGITS-1:0]     digit_en;
   logic                      lz_blank;
   logic [NUM_DIGITS-1:0]     an;
   logic [7:0]                seg;
   logic                      frame_done;

   modport master (
      output clk_1K, value, dp_in, digit_en, lz_blank,
      input  an, seg, frame_done
   );

   modport slave (
      input  clk_1K, value, dp_in, digit_en, lz_blank,
      output an, seg, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_to_seg7 : nibble + decimal point -> active-low segment pattern   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg
);
   assign seg = {~dp, ~FONT[nibble]};
endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan : multiplexed common-anode 7-seg driver, one digit per tick|
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int BLANK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   seg7_scan_if.slave  bus
);
   localparam int                    IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = '1;
   localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);
   localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [7:0]            LAST_BLANK = 8'(BLANK_CYCLES - 1);

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0]     an_q, an_d;
   logic [7:0]                seg_q, seg_d;
   logic                      fd_q, fd_d;
   logic                      prev_1k;
   logic                      latch;

   logic [4*NUM_DIGITS-1:0]   sh_value;
   logic [NUM_DIGITS-1:0]     sh_dp;
   logic [NUM_DIGITS-1:0]     sh_en;
   logic                      sh_lz;

   logic                      tick;
   logic [3:0]                nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]     lz_mask;
   logic                      lz_run;
   logic [7:0]                cur_seg;
   logic                      digit_lit;

   assign tick = bus.clk_1K & ~prev_1k;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
      assign nib[i] = sh_value[4*i +: 4];
   end

   // Blanking runs down from the leftmost digit and stops at the first nonzero one.
   always_comb begin
      lz_mask = '0;
      lz_run  = sh_lz;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz_run     = lz_run & (nib[i] == 4'h0);
         lz_mask[i] = lz_run;
      end
   end

   hex_to_seg7 u_font (
      .nibble (nib[idx_q]),
      .dp     (sh_dp[idx_q]),
      .seg    (cur_seg)
   );

   assign digit_lit = sh_en[idx_q] & ~lz_mask[idx_q];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      an_d    = an_q;
      seg_d   = seg_q;
      fd_d    = 1'b0;
      latch   = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick) begin
               latch   = 1'b1;
               idx_d   = '0;
               cnt_d   = '0;
               an_d    = AN_OFF;
               seg_d   = SEG_OFF;
               state_d = BLANK;
            end
         end
         BLANK: begin
            if (cnt_q == LAST_BLANK) begin
               cnt_d   = '0;
               state_d = DRIVE;
               if (digit_lit) begin
                  an_d  = ~(AN_ONE << idx_q);
                  seg_d = cur_seg;
               end else begin
                  an_d  = AN_OFF;
                  seg_d = SEG_OFF;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DRIVE: begin
            if (tick) begin
               an_d    = AN_OFF;
               seg_d   = SEG_OFF;
               cnt_d   = '0;
               state_d = BLANK;
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  latch = 1'b1;
                  fd_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            an_d    = AN_OFF;
            seg_d   = SEG_OFF;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         an_q     <= AN_OFF;
         seg_q    <= SEG_OFF;
         fd_q     <= 1'b0;
         prev_1k  <= 1'b1;
         sh_value <= '0;
         sh_dp    <= '0;
         sh_en    <= '0;
         sh_lz    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         fd_q    <= fd_d;
         prev_1k <= bus.clk_1K;
         if (latch) begin
            sh_value <= bus.value;
            sh_dp    <= bus.dp_in;
            sh_en    <= bus.digit_en;
            sh_lz    <= bus.lz_blank;
         end
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg7_scan : frame-table bench for seg7_scan with a clk_gen model  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_seg7_scan;
   localparam int NUM_DIGITS   = 4;
   localparam int BLANK_CYCLES = 4;
   localparam int CNT          = 500;

   typedef struct packed {
      logic [15:0]      value;
      logic [3:0]       dp;
      logic [3:0]       en;
      logic             lz;
      logic             mid;
      logic [15:0]      mid_value;
      logic [3:0][3:0]  an;
      logic [3:0][7:0]  seg;
   } vec_t;

   logic clk;
   logic reset;
   int   gen_cnt;
   int   n_checks;
   int   n_fail;
   vec_t vecs [7];

   seg7_scan_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

   seg7_scan #(
      .NUM_DIGITS   (NUM_DIGITS),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // clk_gen model: idles high in reset, toggles every CNT cycles.
   always @(posedge clk) begin
      if (!reset) begin
         bus.clk_1K <= 1'b1;
         gen_cnt    <= 0;
      end else if (gen_cnt == CNT - 1) begin
         bus.clk_1K <= ~bus.clk_1K;
         gen_cnt    <= 0;
      end else begin
         gen_cnt <= gen_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_tick(output bit ok);
      logic last;
      last = bus.clk_1K;
      ok   = 1'b0;
      for (int i = 0; i < 2*CNT + 20; i++) begin
         @(negedge clk);
         if (bus.clk_1K && !last) begin
            ok = 1'b1;
            break;
         end
         last = bus.clk_1K;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL tick_timeout: no scan tick within %0d cycles", 2*CNT + 20);
      end
   endtask

   task automatic apply(input vec_t v);
      bus.value    = v.value;
      bus.dp_in    = v.dp;
      bus.digit_en = v.en;
      bus.lz_blank = v.lz;
   endtask

   // Four slots of one frame; slot s is sampled during the blank window and once driven.
   task automatic run_frame(input vec_t v, input bit first);
      bit ok;
      apply(v);
      for (int s = 0; s < NUM_DIGITS; s++) begin
         wait_tick(ok);
         @(negedge clk);
         check("frame_done_t1", {15'd0, bus.frame_done}, (s == 0 && !first) ? 16'd1 : 16'd0);
         check("blank_an", {12'd0, bus.an}, 16'h000F);
         check("blank_seg", {8'd0, bus.seg}, 16'h00FF);
         for (int k = 2; k <= BLANK_CYCLES; k++) begin
            @(negedge clk);
            check("blank_an", {12'd0, bus.an}, 16'h000F);
            if (k == 2) check("frame_done_t2", {15'd0, bus.frame_done}, 16'd0);
         end
         @(negedge clk);
         check("digit_an", {12'd0, bus.an}, {12'd0, v.an[s]});
         check("digit_seg", {8'd0, bus.seg}, {8'd0, v.seg[s]});
         if (v.mid && s == 1) bus.value = v.mid_value;
      end
   endtask

   initial begin
      bit ok;
      n_checks = 0;
      n_fail   = 0;

      vecs[0] = '{value:16'h1234, dp:4'h0, en:4'hF, lz:1'b0, mid:1'b0, mid_value:16'h0,
                  an:{4'h7, 4'hB, 4'hD, 4'hE}, seg:{8'hF9, 8'hA4, 8'hB0, 8'h99}};
      vecs[1] = '{value:16'h0070, dp:4'h0, en:4'hF, lz:1'b1, mid:1'b0, mid_value:16'h0,
                  an:{4'hF, 4'hF, 4'hD, 4'hE}, seg:{8'hFF, 8'hFF, 8'hF8, 8'hC0}};
      vecs[2] = '{value:16'h1234, dp:4'h0, en:4'hF, lz:1'b0, mid:1'b1, mid_value:16'hABCD,
                  an:{4'h7, 4'hB, 4'hD, 4'hE}, seg:{8'hF9, 8'hA4, 8'hB0, 8'h99}};
      vecs[3] = '{value:16'hABCD, dp:4'h0, en:4'hF, lz:1'b0, mid:1'b0, mid_value:16'h0,
                  an:{4'h7, 4'hB, 4'hD, 4'hE}, seg:{8'h88, 8'h83, 8'hC6, 8'hA1}};
      vecs[4] = '{value:16'h1234, dp:4'h1, en:4'hB, lz:1'b0, mid:1'b0, mid_value:16'h0,
                  an:{4'h7, 4'hF, 4'hD, 4'hE}, seg:{8'hF9, 8'hFF, 8'hB0, 8'h19}};
      vecs[5] = '{value:16'h0000, dp:4'h8, en:4'hF, lz:1'b1, mid:1'b0, mid_value:16'h0,
                  an:{4'hF, 4'hF, 4'hF, 4'hE}, seg:{8'hFF, 8'hFF, 8'hFF, 8'hC0}};
      vecs[6] = '{value:16'h1050, dp:4'h0, en:4'hF, lz:1'b1, mid:1'b0, mid_value:16'h0,
                  an:{4'h7, 4'hB, 4'hD, 4'hE}, seg:{8'hF9, 8'hC0, 8'h92, 8'hC0}};

      reset = 1'b0;
      apply(vecs[0]);
      repeat (5) @(negedge clk);
      check("rst_an", {12'd0, bus.an}, 16'h000F);
      check("rst_seg", {8'd0, bus.seg}, 16'h00FF);
      check("rst_fd", {15'd0, bus.frame_done}, 16'd0);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("release_no_tick_an", {12'd0, bus.an}, 16'h000F);
      check("release_no_tick_seg", {8'd0, bus.seg}, 16'h00FF);

      run_frame(vecs[0], 1'b1);
      for (int v = 1; v < 7; v++) run_frame(vecs[v], 1'b0);

      // Reset in the middle of digit 2's drive window.
      apply(vecs[0]);
      for (int s = 0; s < 3; s++) wait_tick(ok);
      repeat (BLANK_CYCLES + 1) @(negedge clk);
      check("pre_reset_digit2_an", {12'd0, bus.an}, 16'h000B);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_an", {12'd0, bus.an}, 16'h000F);
      check("midrst_seg", {8'd0, bus.seg}, 16'h00FF);
      check("midrst_fd", {15'd0, bus.frame_done}, 16'd0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("rerelease_an", {12'd0, bus.an}, 16'h000F);
      run_frame(vecs[0], 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
